pio_in_edge_irq: RTL and testbench

- Avalon-MM slave input PIO, the read-side counterpart of the LED output PIOs; samples board push-buttons and switches.
- Synchronises in_port and detects edges per bit.
- Latches edges into a sticky edge-capture register and raises a maskable level interrupt to the Nios II processor.
- Sits on the system interconnect beside the output PIOs, using the same register-slot addressing and zero-wait-state reads.

---
 rtl/pio_in_edge_irq_if.sv | 30 +++
 rtl/pio_in_edge_irq.sv | 135 +++++++++++++
 tb/tb_pio_in_edge_irq.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_in_edge_irq_if.sv
`default_nettype none
// ============================================================================
// Module  : pio_in_edge_irq_if
// Brief   : Avalon-MM slave bus bundle for the edge-capturing input PIO.
// Revision: 1.0 - initial release
// ============================================================================
interface pio_in_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module  : pio_in_edge_irq
// Brief   : Input PIO with 2-flop sync, per-bit edge capture and masked irq.
//           Optional debounce stage enabled by defining PIO_DEBOUNCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pio_in_edge_irq #(
    parameter int               WIDTH           = 4,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}},
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_in_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] c_addr_data = 2'd0;
    localparam logic [1:0] c_addr_mask = 2'd2;
    localparam logic [1:0] c_addr_cap  = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      w_readdata;
    logic             w_wr_en;
    logic             w_wr_mask;
    logic             w_wr_cap;
    logic             w_unused;

    assign w_wr_en   = bus.chipselect && !bus.write_n;
    assign w_wr_mask = w_wr_en && (bus.address == c_addr_mask);
    assign w_wr_cap  = w_wr_en && (bus.address == c_addr_cap);
    assign w_unused  = ^bus.writedata;

    // Two-stage synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= RESET_VALUE;
            r_s2 <= RESET_VALUE;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    // A bit only follows the synchroniser once it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_db;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_db  <= RESET_VALUE[i];
            end else if (r_s2[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_db  <= r_s2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_data[i] = r_db;
    end
`else
    assign w_data = r_s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= RESET_VALUE;
        end else begin
            r_prev <= w_data;
        end
    end

    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign w_event = w_data & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign w_event = ~w_data & r_prev;
    end else begin : g_edge_any
        assign w_event = w_data ^ r_prev;
    end

    assign w_clr = w_wr_cap ? bus.writedata[WIDTH-1:0] : '0;

    // Event is OR-ed after the clear so a coincident edge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_event;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_wr_mask) begin
            r_irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            c_addr_data: w_readdata[WIDTH-1:0] = w_data;
            c_addr_mask: w_readdata[WIDTH-1:0] = r_irq_mask;
            c_addr_cap:  w_readdata[WIDTH-1:0] = r_edge_cap;
            default:     w_readdata            = '0;
        endcase
    end

    assign bus.readdata = w_readdata;

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pio_in_edge_irq
// Brief   : Self-checking bench with a history-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pio_in_edge_irq;

    localparam logic [3:0] RV = 4'hF;
    localparam int         DC = 16;
`ifdef PIO_DEBOUNCE_EN
    localparam int         XL = DC;
`else
    localparam int         XL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;

    pio_in_edge_irq_if bus ();

    pio_in_edge_irq #(
        .WIDTH          (4),
        .EDGE_TYPE      (1),
        .RESET_VALUE    (4'hF),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: DATA and edge events derived from the sampled history.
    logic [3:0] hist[$];
    logic [3:0] dhist[$];
    logic [3:0] m_ec;
    logic [3:0] m_mask;
    logic [3:0] m_data;
    logic [3:0] m_db;
    int         m_run[4];

    function automatic logic [3:0] samp(int j);
        if (j < 0) return RV;
        return hist[j];
    endfunction

    function automatic logic [3:0] dh(int j);
        if (j < 0) return RV;
        return dhist[j];
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int         e;
        logic [3:0] s2b, cur, pre, ev, clr;
        if (!reset_n) begin
            hist.delete();
            dhist.delete();
            m_ec   = '0;
            m_mask = '0;
            m_data = RV;
            m_db   = RV;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
        end else begin
            hist.push_back(in_port);
            e = hist.size() - 1;
`ifdef PIO_DEBOUNCE_EN
            s2b = samp(e - 2);
            for (int b = 0; b < 4; b++) begin
                if (s2b[b] !== m_db[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DC) begin
                        m_db[b]  = s2b[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            dhist.push_back(m_db);
`else
            s2b = '0;
            dhist.push_back(samp(e - 1));
`endif
            cur = dh(e - 1);
            pre = dh(e - 2);
            ev  = ~cur & pre;
            clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
            m_ec = (m_ec & ~clr) | ev;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
            m_data = dh(e);
        end
    end

    function automatic logic [31:0] exp_read(logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_data};
            2'd1:    return 32'd0;
            2'd2:    return {28'd0, m_mask};
            default: return {28'd0, m_ec};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] rd);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        rd = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        in_port = RV;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        end
        peek(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h0000000F) begin n_bad++; $display("FAIL reset_data: got %h expected 0000000f", rd); end
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_cap: got %h expected 0", rd); end
        peek(2'd2, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_mask: got %h expected 0", rd); end
    endtask

    task automatic test_falling_irq();
        logic [31:0] rd, exp_d, exp_c;
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        for (int k = 1; k <= 4 + XL; k++) begin
            step();
            exp_d = (k >= 2 + XL) ? 32'hE : 32'hF;
            exp_c = (k >= 3 + XL) ? 32'h1 : 32'h0;
            peek(2'd0, rd);
            n_cmp++;
            if (rd !== exp_d) begin n_bad++; $display("FAIL fall_data k=%0d: got %h expected %h", k, rd, exp_d); end
            peek(2'd3, rd);
            n_cmp++;
            if (rd !== exp_c) begin n_bad++; $display("FAIL fall_cap k=%0d: got %h expected %h", k, rd, exp_c); end
            n_cmp++;
            if (irq !== exp_c[0]) begin n_bad++; $display("FAIL fall_irq k=%0d: got %b expected %b", k, irq, exp_c[0]); end
        end
        bus_write(2'd3, 32'h1);
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_cap: got %h expected 0", rd); end
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_masked_pulse();
        logic [31:0] rd;
        bus_write(2'd2, 32'h0);
        in_port = 4'hF;
        idle(4 + XL);
        in_port = 4'hD;
        idle(1 + XL);
        in_port = 4'hF;
        idle(4 + XL);
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h2) begin n_bad++; $display("FAIL pulse_cap: got %h expected 2", rd); end
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL pulse_irq_masked: got %b expected 0", irq); end
        bus_write(2'd2, 32'h2);
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL pulse_irq_unmask: got %b expected 1", irq); end
        bus_write(2'd3, 32'h2);
    endtask

    task automatic test_clear_race();
        logic [31:0] rd;
        in_port = 4'hB;
        idle(2 + XL);
        bus_write(2'd3, 32'h4);
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h4) begin n_bad++; $display("FAIL race_cap: got %h expected 4", rd); end
        bus_write(2'd3, 32'h4);
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL race_clear: got %h expected 0", rd); end
        in_port = 4'hF;
        idle(4 + XL);
    endtask

    task automatic test_reserved_writes();
        logic [31:0] rd;
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        peek(2'd0, rd);
        n_cmp++;
        if (rd !== 32'hF) begin n_bad++; $display("FAIL rsv_data: got %h expected f", rd); end
        peek(2'd1, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL rsv_read: got %h expected 0", rd); end
        peek(2'd2, rd);
        n_cmp++;
        if (rd !== exp_read(2'd2)) begin n_bad++; $display("FAIL rsv_mask: got %h expected %h", rd, exp_read(2'd2)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [1:0]  a;
        logic        exp_irq;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
                a = 2'($urandom);
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = a;
                bus.writedata  = d;
            end
            step();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            a = 2'($urandom);
            peek(a, rd);
            n_cmp++;
            if (rd !== exp_read(a)) begin n_bad++; $display("FAIL rand_read a=%0d c=%0d: got %h expected %h", a, c, rd, exp_read(a)); end
            exp_irq = |(m_ec & m_mask);
            n_cmp++;
            if (irq !== exp_irq) begin n_bad++; $display("FAIL rand_irq c=%0d: got %b expected %b", c, irq, exp_irq); end
        end
        in_port = 4'hF;
        idle(4 + XL);
        bus_write(2'd3, 32'hF);
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] rd;
        in_port = 4'hF;
        idle(DC + 4);
        bus_write(2'd3, 32'hF);
        in_port = 4'h7;
        idle(10);
        in_port = 4'hF;
        idle(30);
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL db_glitch_cap: got %h expected 0", rd); end
        peek(2'd0, rd);
        n_cmp++;
        if (rd !== 32'hF) begin n_bad++; $display("FAIL db_glitch_data: got %h expected f", rd); end
        in_port = 4'h7;
        idle(20);
        peek(2'd0, rd);
        n_cmp++;
        if (rd !== 32'h7) begin n_bad++; $display("FAIL db_data: got %h expected 7", rd); end
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h8) begin n_bad++; $display("FAIL db_cap: got %h expected 8", rd); end
        in_port = 4'hF;
        idle(DC + 4);
        bus_write(2'd3, 32'hF);
    endtask
`endif

    task automatic test_async_reset();
        logic [31:0] rd;
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        idle(4 + XL);
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL arst_pre_irq: got %b expected 1", irq); end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        in_port = 4'hF;
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL arst_irq: got %b expected 0", irq); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        peek(2'd2, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL arst_mask: got %h expected 0", rd); end
        peek(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL arst_cap: got %h expected 0", rd); end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        test_reset();
        test_falling_irq();
        test_masked_pulse();
        test_clear_race();
        test_reserved_writes();
        test_random();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
